// File: rtl/keccak_iota_lfsr_if.sv
// Handshake bundle for the Keccak iota step: state/round in, iota result and
// applied round constant out, each side with a valid/ready pair.
interface keccak_iota_lfsr_if #(
   parameter int W       = 64,
   parameter int ROUND_W = 5
);
   logic                     in_valid;
   logic                     in_ready;
   logic [ROUND_W-1:0]       in_round;
   logic [4:0][4:0][W-1:0]   in_state;
   logic                     out_valid;
   logic                     out_ready;
   logic [4:0][4:0][W-1:0]   out_state;
   logic [W-1:0]             out_rc;

   modport master (
      output in_valid, in_round, in_state, out_ready,
      input  in_ready, out_valid, out_state, out_rc
   );

   modport slave (
      input  in_valid, in_round, in_state, out_ready,
      output in_ready, out_valid, out_state, out_rc
   );
endinterface

// File: rtl/keccak_iota_lfsr.sv
// Keccak iota step with an on-the-fly round-constant LFSR: consecutive rounds
// reuse the running LFSR, any other round re-seeds and seeks 7*ir steps.
module keccak_iota_lfsr #(
   parameter int W       = 64,
   parameter int ROUND_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   keccak_iota_lfsr_if.slave  io
);

   localparam int L     = $clog2(W);
   localparam int CNT_W = ROUND_W + 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      GEN  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [4:0][4:0][W-1:0] lanes_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
   endfunction

   // Round-constant bit position fed by generation step j.
   function automatic int rc_pos(input logic [2:0] j);
      return (32'sd1 <<< j) - 32'sd1;
   endfunction

   state_t              state_r;
   logic [7:0]          lfsr_r;
   logic [CNT_W-1:0]    seek_cnt_r;
   logic [2:0]          gen_j_r;
   logic [W-1:0]        rc_r;
   lanes_t              cap_state_r;
   logic [ROUND_W-1:0]  cap_round_r;
   logic                cont_r;
   logic [ROUND_W-1:0]  last_round_r;
   logic                in_ready_r;
   logic                out_valid_r;
   lanes_t              out_state_r;
   logic [W-1:0]        out_rc_r;

   logic [CNT_W-1:0]    seek_load_s;
   logic                is_cont_s;
   logic [W-1:0]        rc_next_s;
   lanes_t              result_s;

   // Restart seek length and continuation test, compared one bit wider so max round never wraps.
   always_comb begin
      seek_load_s = ({3'b000, io.in_round} << 3) - {3'b000, io.in_round};
      is_cont_s   = cont_r &&
                    ({1'b0, io.in_round} == ({1'b0, last_round_r} + {{ROUND_W{1'b0}}, 1'b1}));
   end

   // Round constant with the current generation step's bit merged in, and the iota result.
   always_comb begin
      rc_next_s = rc_r;
      for (int b = 0; b < W; b++) begin
         if ((int'(gen_j_r) <= L) && (b == rc_pos(gen_j_r))) begin
            rc_next_s[b] = lfsr_r[0];
         end else begin
            rc_next_s[b] = rc_r[b];
         end
      end
      result_s       = cap_state_r;
      result_s[0][0] = cap_state_r[0][0] ^ rc_next_s;
   end

   // Control FSM, LFSR, round-constant accumulation and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         lfsr_r       <= 8'h01;
         seek_cnt_r   <= '0;
         gen_j_r      <= 3'd0;
         rc_r         <= '0;
         cap_state_r  <= '0;
         cap_round_r  <= '0;
         cont_r       <= 1'b0;
         last_round_r <= '0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         out_state_r  <= '0;
         out_rc_r     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (io.in_valid && in_ready_r) begin
                  cap_state_r <= io.in_state;
                  cap_round_r <= io.in_round;
                  rc_r        <= '0;
                  gen_j_r     <= 3'd0;
                  in_ready_r  <= 1'b0;
                  if (is_cont_s) begin
                     seek_cnt_r <= '0;
                     state_r    <= GEN;
                  end else begin
                     lfsr_r     <= 8'h01;
                     seek_cnt_r <= seek_load_s;
                     state_r    <= (seek_load_s != '0) ? SEEK : GEN;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            SEEK: begin
               lfsr_r     <= lfsr_step(lfsr_r);
               seek_cnt_r <= seek_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               if (seek_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  gen_j_r <= 3'd0;
                  state_r <= GEN;
               end else begin
                  state_r <= SEEK;
               end
            end
            GEN: begin
               rc_r   <= rc_next_s;
               lfsr_r <= lfsr_step(lfsr_r);
               if (gen_j_r == 3'd6) begin
                  gen_j_r      <= 3'd0;
                  cont_r       <= 1'b1;
                  last_round_r <= cap_round_r;
                  out_valid_r  <= 1'b1;
                  out_state_r  <= result_s;
                  out_rc_r     <= rc_next_s;
                  state_r      <= DONE;
               end else begin
                  gen_j_r <= gen_j_r + 3'd1;
               end
            end
            DONE: begin
               if (io.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign io.in_ready  = in_ready_r;
   assign io.out_valid = out_valid_r;
   assign io.out_state = out_state_r;
   assign io.out_rc    = out_rc_r;

endmodule

// File: tb/tb_keccak_iota_lfsr.sv
// Bench for keccak_iota_lfsr: W=64 and W=8 instances against a round-constant
// model built from the LFSR definition, plus known Keccak constants.
module tb_keccak_iota_lfsr;

   logic clk = 1'b0;
   logic reset64, reset8;
   int   checks = 0;
   int   errors = 0;

   logic        exp_act [2];
   logic [63:0] exp_rc  [2];
   logic [63:0] exp_fill[2];
   logic        cont_m  [2];
   int          last_m  [2];

   always #5 clk = ~clk;

   keccak_iota_lfsr_if #(.W(64), .ROUND_W(5)) bus64 ();
   keccak_iota_lfsr_if #(.W(8),  .ROUND_W(5)) bus8 ();

   keccak_iota_lfsr #(.W(64), .ROUND_W(5)) dut64 (.clk(clk), .reset(reset64), .io(bus64.slave));
   keccak_iota_lfsr #(.W(8),  .ROUND_W(5)) dut8  (.clk(clk), .reset(reset8),  .io(bus8.slave));

   // rc(t): LFSR output bit after t steps from the seed
   function automatic logic rc_bit(input int t);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < t; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
      return r[0];
   endfunction

   function automatic logic [63:0] model_rc(input int ir, input int w);
      logic [63:0] res;
      res = 64'd0;
      for (int j = 0; j < 7; j++)
         if ((1 << j) - 1 < w) res[(1 << j) - 1] = rc_bit(7 * ir + j);
      return res;
   endfunction

   function automatic logic cur_rdy(input int k);
      return (k != 0) ? bus8.in_ready : bus64.in_ready;
   endfunction
   function automatic logic cur_ov(input int k);
      return (k != 0) ? bus8.out_valid : bus64.out_valid;
   endfunction
   function automatic logic [63:0] cur_rc(input int k);
      return (k != 0) ? {56'd0, bus8.out_rc} : bus64.out_rc;
   endfunction
   function automatic logic [63:0] cur_lane(input int k, input int x, input int y);
      return (k != 0) ? {56'd0, bus8.out_state[x][y]} : bus64.out_state[x][y];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int k, input logic v, input int ir, input logic [63:0] fill);
      logic [4:0] r5;
      r5 = ir[4:0];
      if (k != 0) begin
         bus8.in_valid = v;
         bus8.in_round = r5;
         for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) bus8.in_state[x][y] = fill[7:0];
      end else begin
         bus64.in_valid = v;
         bus64.in_round = r5;
         for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) bus64.in_state[x][y] = fill;
      end
   endtask

   task automatic set_out_ready(input int k, input logic v);
      if (k != 0) bus8.out_ready = v;
      else        bus64.out_ready = v;
   endtask

   // One transaction: expected latency and constant come from the model; lit_rc pins both.
   task automatic txn(input int k, input int ir, input logic [63:0] fill,
                      input logic [63:0] lit_rc, input int hold);
      int          lat, n;
      logic [63:0] mrc, mfill;
      mrc   = model_rc(ir, (k != 0) ? 8 : 64);
      mfill = (k != 0) ? {56'd0, fill[7:0]} : fill;
      lat   = (cont_m[k] && ir == last_m[k] + 1) ? 7 : 7 * ir + 7;
      chk("model_rc_vs_known", mrc, lit_rc);
      n = 0;
      while (!cur_rdy(k) && n < 20) begin @(posedge clk); #1; n++; end
      chk("in_ready_idle", {63'd0, cur_rdy(k)}, 64'd1);
      exp_rc[k]   = mrc;
      exp_fill[k] = mfill;
      exp_act[k]  = 1'b1;
      drive(k, 1'b1, ir, fill);
      @(posedge clk); #1;
      drive(k, 1'b0, 0, 64'd0);
      chk("in_ready_busy", {63'd0, cur_rdy(k)}, 64'd0);
      n = 0;
      while (!cur_ov(k) && n < 400) begin @(posedge clk); #1; n++; end
      chk("latency", 64'(n), 64'(lat));
      chk("out_rc_known", cur_rc(k), lit_rc);
      chk("lane00_known", cur_lane(k, 0, 0), mfill ^ lit_rc);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", {63'd0, cur_ov(k)}, 64'd1);
         chk("hold_in_ready", {63'd0, cur_rdy(k)}, 64'd0);
      end
      set_out_ready(k, 1'b1);
      @(posedge clk); #1;
      set_out_ready(k, 1'b0);
      exp_act[k] = 1'b0;
      chk("valid_drop", {63'd0, cur_ov(k)}, 64'd0);
      chk("in_ready_after", {63'd0, cur_rdy(k)}, 64'd1);
      cont_m[k] = 1'b1;
      last_m[k] = ir;
   endtask

   // Output compare against the model on every cycle a result is presented.
   always @(negedge clk) begin : cmp
      logic        bad;
      logic [63:0] lane, expl;
      for (int k = 0; k < 2; k++) begin
         if (cur_ov(k)) begin
            bad = 1'b0;
            for (int x = 0; x < 5; x++) begin
               for (int y = 0; y < 5; y++) begin
                  lane = cur_lane(k, x, y);
                  expl = exp_fill[k] ^ ((x == 0 && y == 0) ? exp_rc[k] : 64'd0);
                  if (lane !== expl) bad = 1'b1;
               end
            end
            checks++;
            if (!exp_act[k]) begin
               errors++;
               $display("FAIL spurious_out_valid bus%0d: got valid=1 expected 0", k);
            end else if (bad || cur_rc(k) !== exp_rc[k]) begin
               errors++;
               $display("FAIL cmp_out bus%0d: rc got %h expected %h, lane00 got %h expected %h",
                        k, cur_rc(k), exp_rc[k], cur_lane(k, 0, 0), exp_fill[k] ^ exp_rc[k]);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         exp_act[k] = 1'b0; exp_rc[k] = 64'd0; exp_fill[k] = 64'd0;
         cont_m[k] = 1'b0;  last_m[k] = 0;
         drive(k, 1'b0, 0, 64'd0);
         set_out_ready(k, 1'b0);
      end
      reset64 = 1'b1;
      reset8  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset64 = 1'b0;
      reset8  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("reset_valid", {63'd0, cur_ov(k)}, 64'd0);
         chk("reset_in_ready", {63'd0, cur_rdy(k)}, 64'd1);
         chk("reset_rc", cur_rc(k), 64'd0);
         chk("reset_lane00", cur_lane(k, 0, 0), 64'd0);
      end

      // W=8: rounds 0, 1, then 1 again on the restart path
      txn(1, 0, 64'h00, 64'h01, 0);
      txn(1, 1, 64'hFF, 64'h82, 0);
      txn(1, 1, 64'h5A, 64'h82, 0);

      // W=64: round 0 from reset, continuation to round 1 with a held output
      txn(0, 0, 64'h0, 64'h1, 0);
      txn(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8082, 5);
      chk("lane00_req_value", bus64.out_state[0][0], 64'hFFFF_FFFF_FFFF_7F7D);

      reset64 = 1'b1;
      @(posedge clk); #1;
      reset64 = 1'b0;
      cont_m[0] = 1'b0; last_m[0] = 0;
      txn(0, 23, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_8000_8008, 0);

      // Reset while seeking round 20 discards it
      drive(0, 1'b1, 20, 64'hDEAD_BEEF_0000_1111);
      @(posedge clk); #1;
      drive(0, 1'b0, 0, 64'd0);
      repeat (30) @(posedge clk);
      #1;
      chk("seek_no_valid", {63'd0, bus64.out_valid}, 64'd0);
      reset64 = 1'b1;
      @(posedge clk); #1;
      reset64 = 1'b0;
      cont_m[0] = 1'b0; last_m[0] = 0;
      chk("abort_valid", {63'd0, bus64.out_valid}, 64'd0);
      chk("abort_in_ready", {63'd0, bus64.in_ready}, 64'd1);
      repeat (200) @(posedge clk);
      #1;

      txn(0, 21, 64'hA5A5_A5A5_A5A5_A5A5, 64'h8000_0000_0000_8080, 0);
      txn(0, 22, 64'h0, 64'h8000_0001, 0);
      txn(0, 0, 64'h1234, 64'h1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
